// File: rtl/uart_tx_param_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   t_uart_tx_state : transmitter FSM encoding (3-bit, ST_IDLE = 0)
//   PARITY_*        : values accepted by parm_PARITY
package uart_tx_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } t_uart_tx_state;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO feeding the UART transmitter.
//   clk, rst          : clock and synchronous active-high reset
//   wr_data, wr_en    : push; ignored while full
//   rd_en             : pop; ignored while empty
//   rd_data           : head entry, valid whenever empty is low
//   full, empty, count: occupancy status (count is registered)
module uart_tx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a write FIFO.
//   i_clk_40mhz, i_rst_40mhz : clock, synchronous active-high reset
//   i_tx_data, i_tx_valid    : byte write; accepted when o_tx_ready is high
//   o_tx_ready               : FIFO not full
//   o_tx_almost_full         : fewer than parm_AF_MARGIN free slots
//   o_fifo_count             : FIFO occupancy
//   o_busy                   : frame in progress or bytes queued
//   eo_uart_tx               : registered serial line, idle high
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int parm_CLK_DIVISOR = 347,
    parameter int parm_DATA_BITS   = 8,
    parameter int parm_PARITY      = 0,
    parameter int parm_STOP_BITS   = 1,
    parameter int parm_FIFO_DEPTH  = 512,
    parameter int parm_AF_MARGIN   = 35
) (
    input  logic                               i_clk_40mhz,
    input  logic                               i_rst_40mhz,
    input  logic [7:0]                         i_tx_data,
    input  logic                               i_tx_valid,
    output logic                               o_tx_ready,
    output logic                               o_tx_almost_full,
    output logic [$clog2(parm_FIFO_DEPTH):0]   o_fifo_count,
    output logic                               o_busy,
    output logic                               eo_uart_tx
);

    localparam int CW = $clog2(parm_FIFO_DEPTH) + 1;

    if (parm_CLK_DIVISOR < 4 || parm_CLK_DIVISOR > 65535) begin : g_bad_div
        $error("uart_tx_param: parm_CLK_DIVISOR must be 4..65535");
    end
    if (parm_DATA_BITS < 5 || parm_DATA_BITS > 8) begin : g_bad_bits
        $error("uart_tx_param: parm_DATA_BITS must be 5..8");
    end
    if (parm_PARITY < PARITY_NONE || parm_PARITY > PARITY_ODD) begin : g_bad_par
        $error("uart_tx_param: parm_PARITY must be 0, 1 or 2");
    end
    if (parm_STOP_BITS < 1 || parm_STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: parm_STOP_BITS must be 1 or 2");
    end
    if (parm_FIFO_DEPTH < 16 || parm_FIFO_DEPTH > 4096 ||
        (parm_FIFO_DEPTH & (parm_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: parm_FIFO_DEPTH must be a power of 2 in 16..4096");
    end
    if (parm_AF_MARGIN < 0 || parm_AF_MARGIN > parm_FIFO_DEPTH) begin : g_bad_af
        $error("uart_tx_param: parm_AF_MARGIN must be 0..parm_FIFO_DEPTH");
    end

    localparam logic [15:0]   BAUD_LAST = 16'(parm_CLK_DIVISOR - 1);
    localparam logic [2:0]    DATA_LAST = 3'(parm_DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(parm_STOP_BITS - 1);
    // free < margin  <=>  count > depth - margin
    localparam logic [CW-1:0] AF_LEVEL  = CW'(parm_FIFO_DEPTH - parm_AF_MARGIN);
    localparam logic          ODD_PAR   = (parm_PARITY == PARITY_ODD);

    // ---------------------------------------------------------------- FIFO
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    uart_tx_sync_fifo #(
        .DEPTH (parm_FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (i_clk_40mhz),
        .rst     (i_rst_40mhz),
        .wr_data (i_tx_data),
        .wr_en   (i_tx_valid),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_fifo_count)
    );

    assign o_tx_ready       = !fifo_full;
    assign o_tx_almost_full = (o_fifo_count > AF_LEVEL);

    // ------------------------------------------------------- baud counter
    logic [15:0] baud_cnt;
    logic        tick;

    assign tick = (baud_cnt == BAUD_LAST);

    always_ff @(posedge i_clk_40mhz) begin
        if (i_rst_40mhz)  baud_cnt <= '0;
        else if (tick)    baud_cnt <= '0;
        else              baud_cnt <= baud_cnt + 16'd1;
    end

    // ---------------------------------------------------------------- FSM
    // state_q names the bit currently on the line; line_q is loaded with
    // that bit on the same tick that enters the state.
    t_uart_tx_state              state_q, state_d;
    logic [2:0]                  idx_q, idx_d;   // data index, reused as stop count
    logic [parm_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        line_q, line_d;
    logic                        parity_bit;

    assign parity_bit = (^shift_q) ^ ODD_PAR;

    always_ff @(posedge i_clk_40mhz) begin
        if (i_rst_40mhz) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        line_d  = line_q;
        pop     = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    line_d = 1'b1;
                    if (!fifo_empty) begin
                        state_d = ST_START;
                        shift_d = fifo_head[parm_DATA_BITS-1:0];
                        pop     = 1'b1;
                        line_d  = 1'b0;
                    end
                end
                ST_START: begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    line_d  = shift_q[0];
                end
                ST_DATA: begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (parm_PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            line_d  = parity_bit;
                        end else begin
                            state_d = ST_STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        line_d = shift_q[idx_d];
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
                ST_STOP: begin
                    line_d = 1'b1;
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // Chain straight into the next start bit when data waits.
                        if (!fifo_empty) begin
                            state_d = ST_START;
                            shift_d = fifo_head[parm_DATA_BITS-1:0];
                            pop     = 1'b1;
                            line_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
            endcase
        end
    end

    assign eo_uart_tx = line_q;
    assign o_busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover 8N1, 7E2, 7O1
// and a small FIFO with no baud ticks.
module tb_uart_tx_param;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid [4];
    logic [7:0] data  [4];
    logic       line  [4];
    logic       busy  [4];
    logic       ready [4];
    logic       af    [4];
    logic [9:0] cnt0, cnt1, cnt2;
    logic [4:0] cnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.parm_CLK_DIVISOR(DIV)) u_8n1 (
        .i_clk_40mhz(clk), .i_rst_40mhz(rst), .i_tx_data(data[0]), .i_tx_valid(valid[0]),
        .o_tx_ready(ready[0]), .o_tx_almost_full(af[0]), .o_fifo_count(cnt0),
        .o_busy(busy[0]), .eo_uart_tx(line[0]));

    uart_tx_param #(.parm_CLK_DIVISOR(DIV), .parm_DATA_BITS(7), .parm_PARITY(1),
                    .parm_STOP_BITS(2)) u_7e2 (
        .i_clk_40mhz(clk), .i_rst_40mhz(rst), .i_tx_data(data[1]), .i_tx_valid(valid[1]),
        .o_tx_ready(ready[1]), .o_tx_almost_full(af[1]), .o_fifo_count(cnt1),
        .o_busy(busy[1]), .eo_uart_tx(line[1]));

    uart_tx_param #(.parm_CLK_DIVISOR(DIV), .parm_DATA_BITS(7), .parm_PARITY(2),
                    .parm_STOP_BITS(1)) u_7o1 (
        .i_clk_40mhz(clk), .i_rst_40mhz(rst), .i_tx_data(data[2]), .i_tx_valid(valid[2]),
        .o_tx_ready(ready[2]), .o_tx_almost_full(af[2]), .o_fifo_count(cnt2),
        .o_busy(busy[2]), .eo_uart_tx(line[2]));

    uart_tx_param #(.parm_CLK_DIVISOR(65535), .parm_FIFO_DEPTH(16),
                    .parm_AF_MARGIN(4)) u_fifo (
        .i_clk_40mhz(clk), .i_rst_40mhz(rst), .i_tx_data(data[3]), .i_tx_valid(valid[3]),
        .o_tx_ready(ready[3]), .o_tx_almost_full(af[3]), .o_fifo_count(cnt3),
        .o_busy(busy[3]), .eo_uart_tx(line[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; one write is accepted on the following posedge.
    task automatic wr(input int s, input logic [7:0] d);
        valid[s] = 1'b1;
        data[s]  = d;
        @(negedge clk);
        valid[s] = 1'b0;
    endtask

    // bits[0] is the first line bit (start). Each bit is sampled DIV times.
    task automatic expect_frame(input int s, input logic [31:0] bits, input int nbits,
                                input bit wait_low, input string tag);
        int         n;
        logic [3:0] samp;
        logic       all_busy;
        n = 0;
        if (wait_low) begin
            while (line[s] === 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_start_seen"}, {31'd0, line[s]}, 32'd0);
        end
        all_busy = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < DIV; c++) begin
                samp[c]  = line[s];
                all_busy = all_busy & busy[s];
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, b), {28'd0, samp}, bits[b] ? 32'hF : 32'h0);
        end
        check({tag, "_busy_in_frame"}, {31'd0, all_busy}, 32'd1);
    endtask

    initial begin
        logic quiet;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        // A write held during reset must be ignored.
        valid[0] = 1'b1;
        data[0]  = 8'hEE;
        repeat (3) @(negedge clk);
        check("rst_line",  {31'd0, line[0]},  32'd1);
        check("rst_cnt",   {22'd0, cnt0},     32'd0);
        check("rst_ready", {31'd0, ready[0]}, 32'd1);
        check("rst_af",    {31'd0, af[0]},    32'd0);
        check("rst_busy",  {31'd0, busy[0]},  32'd0);
        check("rst_af16",  {31'd0, af[3]},    32'd0);
        check("rst_cnt16", {27'd0, cnt3},     32'd0);
        rst      = 1'b0;
        valid[0] = 1'b0;
        @(negedge clk);
        check("rst_write_dropped", {22'd0, cnt0}, 32'd0);

        // Small FIFO, no ticks: almost-full when free slots < 4.
        for (int i = 0; i < 12; i++) wr(3, 8'(i));
        check("af_at12",    {31'd0, af[3]},    32'd0);
        check("cnt_at12",   {27'd0, cnt3},     32'd12);
        check("ready_at12", {31'd0, ready[3]}, 32'd1);
        wr(3, 8'hAA);
        check("af_at13",    {31'd0, af[3]},    32'd1);
        check("cnt_at13",   {27'd0, cnt3},     32'd13);
        for (int i = 0; i < 3; i++) wr(3, 8'hA0);
        check("ready_at16", {31'd0, ready[3]}, 32'd0);
        check("cnt_at16",   {27'd0, cnt3},     32'd16);
        wr(3, 8'hBB);
        check("cnt_after17",   {27'd0, cnt3},     32'd16);
        check("ready_after17", {31'd0, ready[3]}, 32'd0);

        // 8N1 0x55
        wr(0, 8'h55);
        expect_frame(0, {22'd0, 1'b1, 8'h55, 1'b0}, 10, 1'b1, "f55");
        check("f55_idle_line", {31'd0, line[0]}, 32'd1);
        check("f55_busy_off",  {31'd0, busy[0]}, 32'd0);

        // 7E2 0x41: two ones -> even parity 0, then two stop bits
        wr(1, 8'h41);
        expect_frame(1, {21'd0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, 1'b1, "f7e2");
        check("f7e2_busy_off", {31'd0, busy[1]}, 32'd0);

        // 7O1 0xC1: bit 7 ignored, data 1000001 -> odd parity 1
        wr(2, 8'hC1);
        expect_frame(2, {22'd0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 1'b1, "f7o1");
        check("f7o1_busy_off", {31'd0, busy[2]}, 32'd0);

        // Back-to-back frames; writes land before the next tick.
        wr(0, 8'h01);
        wr(0, 8'h02);
        wr(0, 8'h03);
        expect_frame(0, {2'd0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0},
                     30, 1'b1, "f123");
        check("f123_busy_off", {31'd0, busy[0]}, 32'd0);
        check("f123_cnt",      {22'd0, cnt0},    32'd0);

        // Reset during data bit 1 of 0xA5 with five bytes queued.
        wr(0, 8'hA5);
        wr(0, 8'h11);
        wr(0, 8'h22);
        wr(0, 8'h33);
        wr(0, 8'h44);
        wr(0, 8'h55);
        repeat (6) @(negedge clk);
        check("mid_cnt",  {22'd0, cnt0},    32'd5);
        check("mid_line", {31'd0, line[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_line",  {31'd0, line[0]},  32'd1);
        check("abort_cnt",   {22'd0, cnt0},     32'd0);
        check("abort_busy",  {31'd0, busy[0]},  32'd0);
        check("abort_ready", {31'd0, ready[0]}, 32'd1);
        rst   = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            quiet = quiet & line[0] & ~busy[0];
            @(negedge clk);
        end
        check("abort_quiet", {31'd0, quiet}, 32'd1);

        // Write lands on the pop edge (4th edge after reset) with count 1.
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        valid[0] = 1'b1;
        data[0]  = 8'h3C;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'hC3;
        @(negedge clk);
        valid[0] = 1'b0;
        check("coin_cnt",   {22'd0, cnt0},    32'd1);
        check("coin_start", {31'd0, line[0]}, 32'd0);
        expect_frame(0, {12'd0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}, 20, 1'b0, "fcoin");
        check("fcoin_busy_off", {31'd0, busy[0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
